serial_cmp_ctrl: RTL and testbench

Sequencing controller that reuses one 2-bit magnitude-comparator slice to compare two WIDTH-bit unsigned operands serially, MSB pair first, one slice per cycle. It sits between a requester issuing compare jobs over a valid/ready handshake and a consumer taking a one-hot gt/eq/lt result. It exits early on the first unequal slice when enabled.

---
 rtl/cmp_pkg.sv | 34 +++
 rtl/cmp2_slice.sv | 25 ++
 rtl/serial_cmp_ctrl.sv | 148 ++++++++++++++
 tb/tb_serial_cmp_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_pkg
//  Description : Shared types and helpers for the serial comparator controller:
//                FSM state encoding, per-slice compare result, and slice-count
//                and counter-width helpers derived from the operand width.
//  Revision    : 1.0  initial release
// ============================================================================
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } slice_res_t;

    // Number of 2-bit slices in an operand.
    function automatic int slice_count(input int width);
        return width / 2;
    endfunction

    // Width of a counter indexing all slices; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (slice_count(width) > 1) ? $clog2(slice_count(width)) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp2_slice.sv
`default_nettype none
// ============================================================================
//  Module      : cmp2_slice
//  Description : Purely combinational 2-bit unsigned magnitude comparator.
//                Exactly one of gt/eq/lt is high for any input pair.
//  Ports       : x, y  in  [1:0]  operands
//                gt    out        x > y
//                eq    out        x == y
//                lt    out        x < y
//  Revision    : 1.0  initial release
// ============================================================================
module cmp2_slice (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    assign gt = (x > y);
    assign eq = (x == y);
    assign lt = (x < y);

endmodule
`default_nettype wire

// File: rtl/serial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_cmp_ctrl
//  Description : Compares two WIDTH-bit unsigned operands serially through one
//                shared 2-bit comparator slice, MSB pair first, one slice per
//                cycle. Optional early exit on the first unequal slice.
//  Ports       : clk, rst_n              clock, async active-low reset
//                start_valid/start_ready job handshake (a, b sampled on accept)
//                abort                   synchronous cancel, highest priority
//                busy                    high while slices are being examined
//                res_valid/res_ready     result handshake
//                gt, eq, lt              registered one-hot verdict
//  Revision    : 1.0  initial release
// ============================================================================
module serial_cmp_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int c_NSLICE = slice_count(WIDTH);
    localparam int c_CNT_W  = cnt_width(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sticky_gt;
    logic               r_sticky_lt;
    slice_res_t         w_slice;
    logic               w_unequal;
    logic               w_last;

    cmp2_slice u_slice (
        .x  (r_sa[WIDTH-1:WIDTH-2]),
        .y  (r_sb[WIDTH-1:WIDTH-2]),
        .gt (w_slice.gt),
        .eq (w_slice.eq),
        .lt (w_slice.lt)
    );

    assign w_unequal = w_slice.gt | w_slice.lt;
    assign w_last    = (r_cnt == '0);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (start_valid) w_state_nxt = RUN;
                RUN:  if ((EARLY_EXIT && w_unequal) || w_last) w_state_nxt = DONE;
                DONE: if (res_ready) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        start_ready = (r_state == IDLE);
        busy        = (r_state == RUN);
        res_valid   = (r_state == DONE);
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa        <= '0;
            r_sb        <= '0;
            r_cnt       <= '0;
            r_sticky_gt <= 1'b0;
            r_sticky_lt <= 1'b0;
            gt          <= 1'b0;
            eq          <= 1'b0;
            lt          <= 1'b0;
        end else if (abort) begin
            r_sticky_gt <= 1'b0;
            r_sticky_lt <= 1'b0;
            gt          <= 1'b0;
            eq          <= 1'b0;
            lt          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_sa        <= a;
                        r_sb        <= b;
                        r_cnt       <= c_CNT_W'(c_NSLICE - 1);
                        r_sticky_gt <= 1'b0;
                        r_sticky_lt <= 1'b0;
                        gt          <= 1'b0;
                        eq          <= 1'b0;
                        lt          <= 1'b0;
                    end
                end
                RUN: begin
                    if (EARLY_EXIT && w_unequal) begin
                        gt <= w_slice.gt;
                        lt <= w_slice.lt;
                    end else if (w_last) begin
                        // An earlier unequal slice outranks the final one.
                        gt <= r_sticky_gt | (~r_sticky_lt & w_slice.gt);
                        lt <= r_sticky_lt | (~r_sticky_gt & w_slice.lt);
                        eq <= ~r_sticky_gt & ~r_sticky_lt & w_slice.eq;
                    end else begin
                        r_sa  <= r_sa << 2;
                        r_sb  <= r_sb << 2;
                        r_cnt <= r_cnt - 1'b1;
                        if (!r_sticky_gt && !r_sticky_lt) begin
                            r_sticky_gt <= w_slice.gt;
                            r_sticky_lt <= w_slice.lt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_cmp_ctrl
//  Description : Self-checking bench for serial_cmp_ctrl. Instance 0 has early
//                exit enabled, instance 1 always examines every slice.
//                Expected verdict and latency come from a reference model and
//                travel through a scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_cmp_ctrl;

    localparam int c_W = 8;
    localparam int c_N = c_W / 2;

    typedef struct {
        logic [2:0] res;   // {gt, eq, lt}
        int         k;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [1:0]      start_valid;
    logic [1:0]      start_ready;
    logic [c_W-1:0]  a_in [2];
    logic [c_W-1:0]  b_in [2];
    logic [1:0]      abort;
    logic [1:0]      busy;
    logic [1:0]      res_valid;
    logic [1:0]      res_ready;
    logic [1:0]      gt;
    logic [1:0]      eq;
    logic [1:0]      lt;

    exp_t q_exp [$];
    int   n_checks;
    int   n_pass;

    serial_cmp_ctrl #(.WIDTH(c_W), .EARLY_EXIT(1'b1)) u_dut_early (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid[0]), .start_ready(start_ready[0]),
        .a(a_in[0]), .b(b_in[0]), .abort(abort[0]), .busy(busy[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .gt(gt[0]), .eq(eq[0]), .lt(lt[0])
    );

    serial_cmp_ctrl #(.WIDTH(c_W), .EARLY_EXIT(1'b0)) u_dut_full (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid[1]), .start_ready(start_ready[1]),
        .a(a_in[1]), .b(b_in[1]), .abort(abort[1]), .busy(busy[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .gt(gt[1]), .eq(eq[1]), .lt(lt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    // Reference: walk slices MSB first; first unequal slice decides.
    function automatic exp_t model(input logic [c_W-1:0] av, input logic [c_W-1:0] bv,
                                   input bit early);
        exp_t e;
        logic [1:0] xa, xb;
        e.res = 3'b010;
        e.k   = c_N;
        for (int j = 1; j <= c_N; j++) begin
            xa = av[c_W-2*j +: 2];
            xb = bv[c_W-2*j +: 2];
            if (xa != xb) begin
                e.res = (xa > xb) ? 3'b100 : 3'b001;
                if (early) e.k = j;
                return e;
            end
        end
        return e;
    endfunction

    function automatic logic [2:0] res_of(input int d);
        return {gt[d], eq[d], lt[d]};
    endfunction

    task automatic run_job(input int d, input logic [c_W-1:0] av, input logic [c_W-1:0] bv,
                           input int hold);
        exp_t e;
        int   k;
        q_exp.push_back(model(av, bv, d == 0));
        @(negedge clk);
        chk("ready_idle", 32'(start_ready[d]), 32'd1);
        start_valid[d] = 1'b1;
        a_in[d] = av;
        b_in[d] = bv;
        @(posedge clk);
        #1;
        start_valid[d] = 1'b0;
        a_in[d] = c_W'($urandom);
        b_in[d] = c_W'($urandom);
        chk("busy_run", 32'(busy[d]), 32'd1);
        k = 0;
        do begin
            @(posedge clk);
            k++;
            #1;
        end while (!res_valid[d] && k < 20);
        e = q_exp.pop_front();
        chk("latency", 32'(k), 32'(e.k));
        chk("result", 32'(res_of(d)), 32'(e.res));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold", 32'({res_valid[d], res_of(d)}), 32'({1'b1, e.res}));
        end
        res_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        res_ready[d] = 1'b0;
        chk("consumed", 32'({start_ready[d], res_valid[d], busy[d]}), 32'b100);
        chk("kept", 32'(res_of(d)), 32'(e.res));
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        start_valid = '0;
        abort       = '0;
        res_ready   = '0;
        for (int d = 0; d < 2; d++) begin
            a_in[d] = '0;
            b_in[d] = '0;
        end

        // Reset state
        #12;
        for (int d = 0; d < 2; d++)
            chk("reset", 32'({start_ready[d], busy[d], res_valid[d], res_of(d)}), 32'b100000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed jobs
        run_job(0, 8'hC0, 8'h40, 0);
        run_job(0, 8'hA5, 8'hA5, 3);
        run_job(1, 8'h13, 8'h12, 0);
        run_job(1, 8'h80, 8'h7F, 1);
        run_job(0, 8'h80, 8'h7F, 0);
        run_job(1, 8'h12, 8'h13, 0);
        run_job(0, 8'h00, 8'hFF, 0);
        run_job(1, 8'hA5, 8'hA5, 0);

        // Abort at E2 of a full-equal job
        @(negedge clk);
        start_valid[0] = 1'b1;
        a_in[0] = 8'hA5;
        b_in[0] = 8'hA5;
        @(posedge clk);
        #1;
        start_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        abort[0] = 1'b1;
        @(posedge clk);
        #1;
        abort[0] = 1'b0;
        chk("abort_state", 32'({start_ready[0], busy[0], res_valid[0], res_of(0)}), 32'b100000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_res", 32'(res_valid[0]), 32'd0);
        end

        // Job offered together with abort is refused
        @(negedge clk);
        start_valid[0] = 1'b1;
        abort[0] = 1'b1;
        @(posedge clk);
        #1;
        start_valid[0] = 1'b0;
        abort[0] = 1'b0;
        chk("abort_refuse", 32'({start_ready[0], busy[0]}), 32'b10);
        run_job(0, 8'h01, 8'h02, 0);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        start_valid[1] = 1'b1;
        a_in[1] = 8'h3C;
        b_in[1] = 8'h3C;
        @(posedge clk);
        #1;
        start_valid[1] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 32'({start_ready[1], busy[1], res_valid[1], res_of(1)}), 32'b100000);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(1, 8'h55, 8'h54, 0);

        // Random jobs on both instances
        for (int i = 0; i < 12; i++) begin
            logic [c_W-1:0] ra, rb;
            ra = c_W'($urandom);
            rb = (i % 4 == 0) ? ra : c_W'($urandom);
            run_job(i % 2, ra, rb, i % 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
